// File: rtl/add_pipe_if.sv
// Operand/result handshake bundle for add_pipe.
// Operands are declared [0:WIDTH-1] with bit 0 as the LSB.
interface add_pipe_if #(
  parameter int WIDTH = 8
);
  logic [0:WIDTH-1] in_a;
  logic [0:WIDTH-1] in_b;
  logic             carry_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_a, in_b, carry_in, in_valid, out_ready,
    input  in_ready, sum, carry_out, out_valid
  );

  modport slave (
    input  in_a, in_b, carry_in, in_valid, out_ready,
    output in_ready, sum, carry_out, out_valid
  );
endinterface

// File: rtl/add_pipe.sv
// Pipelined ripple-chunk adder, one CHUNK-bit slice per stage.
// ADD_PIPE_SAT_EN: last stage clamps sum to all-ones on overflow.
module add_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic      clk,
  input logic      reset,
  add_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("add_pipe: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;

  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] v_r;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic [STAGES-1:0] adv;

  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_in[i] = bus.in_a[i];
      b_in[i] = bus.in_b[i];
    end
  end

  // Stage k is fed by the port for k=0, else by stage k-1.
  always_comb begin
    src_a[0] = a_in;
    src_b[0] = b_in;
    src_s[0] = '0;
    src_c[0] = bus.carry_in;
    src_v[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_r[k-1];
      src_b[k] = b_r[k-1];
      src_s[k] = s_r[k-1];
      src_c[k] = c_r[k-1];
      src_v[k] = v_r[k-1];
    end
  end

  always_comb begin
    logic [CHUNK:0] t;
    t     = '0;
    nxt_c = '0;
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
        + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
        + {{CHUNK{1'b0}}, src_c[k]};
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      nxt_c[k] = t[CHUNK];
`ifdef ADD_PIPE_SAT_EN
      if (k == STAGES - 1 && t[CHUNK]) begin
        nxt_s[k] = '1;
      end
`endif
    end
  end

  // A stage may load when it is empty or its successor moves.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    adv   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain  = ~v_r[k] | chain;
      adv[k] = chain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_r <= '0;
      c_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_r[k] <= src_v[k];
          c_r[k] <= nxt_c[k];
          a_r[k] <= src_a[k];
          b_r[k] <= src_b[k];
          s_r[k] <= nxt_s[k];
        end
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.sum       = s_r[STAGES-1];
  assign bus.carry_out = c_r[STAGES-1];
  assign bus.out_valid = v_r[STAGES-1];
endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: directed table and corner sequences on CHUNK=4,
// random scoreboard on CHUNK=4, 8 and 2.
module tb_add_pipe;
  localparam int W = 8;
`ifdef ADD_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_pipe_if #(.WIDTH(W)) bus4 ();
  add_pipe_if #(.WIDTH(W)) bus8 ();
  add_pipe_if #(.WIDTH(W)) bus2 ();

  add_pipe #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk(clk), .reset(rst), .bus(bus4.slave)
  );
  add_pipe #(.WIDTH(W), .CHUNK(8)) u_dut8 (
    .clk(clk), .reset(rst), .bus(bus8.slave)
  );
  add_pipe #(.WIDTH(W), .CHUNK(2)) u_dut2 (
    .clk(clk), .reset(rst), .bus(bus2.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  function automatic logic [0:W-1] port_of(input logic [W-1:0] x);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) r[i] = x[i];
    return r;
  endfunction

  // Reference: {co,sum} = a+b+cin, optionally clamped on overflow.
  function automatic logic [W:0] model(input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic c);
    int unsigned t;
    logic [W:0] r;
    t = int'(a) + int'(b) + int'(c);
    r = t[W:0];
    if (SAT && r[W]) r[W-1:0] = '1;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic put(input int cfg, input logic v,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic ordy);
    case (cfg)
      0: begin
        bus4.in_valid = v; bus4.in_a = port_of(a);
        bus4.in_b = port_of(b); bus4.carry_in = c;
        bus4.out_ready = ordy;
      end
      1: begin
        bus8.in_valid = v; bus8.in_a = port_of(a);
        bus8.in_b = port_of(b); bus8.carry_in = c;
        bus8.out_ready = ordy;
      end
      default: begin
        bus2.in_valid = v; bus2.in_a = port_of(a);
        bus2.in_b = port_of(b); bus2.carry_in = c;
        bus2.out_ready = ordy;
      end
    endcase
  endtask

  task automatic get(input int cfg, output logic irdy,
                     output logic ovld, output logic [W:0] res);
    case (cfg)
      0: begin
        irdy = bus4.in_ready; ovld = bus4.out_valid;
        res = {bus4.carry_out, bus4.sum};
      end
      1: begin
        irdy = bus8.in_ready; ovld = bus8.out_valid;
        res = {bus8.carry_out, bus8.sum};
      end
      default: begin
        irdy = bus2.in_ready; ovld = bus2.out_valid;
        res = {bus2.carry_out, bus2.sum};
      end
    endcase
  endtask

  // One op on an idle CHUNK=4 pipe; expects result after 2 cycles.
  task automatic run_one(input vec_t v, input string name);
    logic irdy, ovld;
    logic [W:0] res;
    int lat;
    logic [W:0] exp;
    exp = {v.co, v.s};
    if (SAT && v.co) exp[W-1:0] = '1;
    put(0, 1'b1, v.a, v.b, v.c, 1'b1);
    #1 get(0, irdy, ovld, res);
    check({name, "_rdy"}, 16'(irdy), 16'd1);
    lat = 0;
    do begin
      @(negedge clk);
      put(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      lat++;
      #1 get(0, irdy, ovld, res);
    end while (!ovld && lat < 10);
    check({name, "_lat"}, 16'(lat), 16'd2);
    check({name, "_res"}, 16'(res), 16'(exp));
  endtask

  task automatic rand_run(input int cfg, input int n_ops);
    logic irdy, ovld, pend, hold_v, c, ordy;
    logic [W-1:0] a, b;
    logic [W:0] res, held;
    logic [W:0] q[$];
    int issued, got, cyc;
    pend = 1'b0; hold_v = 1'b0; held = '0;
    a = '0; b = '0; c = 1'b0;
    issued = 0; got = 0; cyc = 0;
    while (got < n_ops && cyc < 20000) begin
      @(negedge clk);
      if (!pend && issued < n_ops && $urandom_range(3) != 0) begin
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        pend = 1'b1;
      end
      ordy = ($urandom_range(3) != 0);
      put(cfg, pend, a, b, c, ordy);
      #1 get(cfg, irdy, ovld, res);
      if (hold_v) check("rnd_hold", 16'({ovld, res}), 16'({1'b1, held}));
      if (ovld && ordy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rnd_spurious cfg %0d: got %h want none", cfg, res);
        end else begin
          check("rnd_res", 16'(res), 16'(q.pop_front()));
        end
        got++;
      end
      if (pend && irdy) begin
        q.push_back(model(a, b, c));
        pend = 1'b0;
        issued++;
      end
      hold_v = ovld && !ordy;
      held = res;
      cyc++;
    end
    @(negedge clk);
    put(cfg, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("rnd_count", 16'(got), 16'(n_ops));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t b2b[3];
    logic irdy, ovld;
    logic [W:0] res, held;
    logic [W:0] q[$];
    logic [W-1:0] sa[3], sb[3];
    int acc, got, cyc;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[3] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    tbl[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    tbl[5] = '{8'h08, 8'h08, 1'b0, 8'h10, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    b2b[0] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    b2b[1] = '{8'hF0, 8'h10, 1'b1, 8'h01, 1'b1};
    b2b[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    for (int i = 0; i < 3; i++) put(i, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // reset held 3 cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 get(0, irdy, ovld, res);
    check("rst_valid", 16'(ovld), 16'd0);
    check("rst_data", 16'(res), 16'd0);
    check("rst_ready", 16'(irdy), 16'd1);

    for (int i = 0; i < 8; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // back-to-back issue, results on consecutive cycles
    for (int cyc2 = 0; cyc2 < 5; cyc2++) begin
      @(negedge clk);
      if (cyc2 < 3)
        put(0, 1'b1, b2b[cyc2].a, b2b[cyc2].b, b2b[cyc2].c, 1'b1);
      else
        put(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      #1 get(0, irdy, ovld, res);
      if (cyc2 < 3) check("b2b_rdy", 16'(irdy), 16'd1);
      if (cyc2 >= 2) begin
        check("b2b_valid", 16'(ovld), 16'd1);
        check("b2b_res", 16'(res),
              16'(model(b2b[cyc2-2].a, b2b[cyc2-2].b, b2b[cyc2-2].c)));
      end
    end

    // stall 5 cycles with 3 ops offered
    sa[0] = 8'h21; sb[0] = 8'h0F;
    sa[1] = 8'hE0; sb[1] = 8'h30;
    sa[2] = 8'h05; sb[2] = 8'h0B;
    acc = 0; held = '0;
    for (int cyc2 = 0; cyc2 < 5; cyc2++) begin
      @(negedge clk);
      put(0, 1'b1, sa[acc], sb[acc], 1'b0, 1'b0);
      #1 get(0, irdy, ovld, res);
      if (ovld && cyc2 > 2) check("stall_hold", 16'(res), 16'(held));
      if (ovld) held = res;
      if (irdy) begin
        q.push_back(model(sa[acc], sb[acc], 1'b0));
        acc++;
      end
    end
    check("stall_acc", 16'(acc), 16'd2);
    check("stall_rdy", 16'(irdy), 16'd0);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      @(negedge clk);
      if (acc < 3) put(0, 1'b1, sa[acc], sb[acc], 1'b0, 1'b1);
      else put(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      #1 get(0, irdy, ovld, res);
      if (ovld) begin
        if (q.size() > 0) check("drain_res", 16'(res), 16'(q.pop_front()));
        got++;
      end
      if (acc < 3 && irdy) begin
        q.push_back(model(sa[acc], sb[acc], 1'b0));
        acc++;
      end
      cyc++;
    end
    check("drain_cnt", 16'(got), 16'd3);

    // reset with two results in flight
    @(negedge clk);
    put(0, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
    @(negedge clk);
    put(0, 1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
    @(negedge clk);
    put(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 get(0, irdy, ovld, res);
    check("mid_rst_valid", 16'(ovld), 16'd0);
    check("mid_rst_data", 16'(res), 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 get(0, irdy, ovld, res);
      check("no_stale", 16'(ovld), 16'd0);
    end

    for (int cfg = 0; cfg < 3; cfg++) rand_run(cfg, 2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
